microwave_timer: RTL and testbench

//   Microwave cook timer, directly downstream of the 1 Hz divider: consumes its one-cycle

---
 rtl/microwave_timer.sv | 154 +++++++++++++++
 tb/tb_microwave_timer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_timer.sv
// Microwave cook timer: keypad-entered BCD MM:SS counted down on 1 Hz ticks,
// with door interlock, pause/resume, quick start and a timed completion beep.
module microwave_timer #(
  parameter logic [15:0] QUICK_START = 16'h0030,
  parameter logic [3:0]  BEEP_SECS   = 4'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       magnetron_on,
  output logic       beep,
  output logic       done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSet   = 3'd1,
    StCook  = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e      state_q;
  logic [15:0] time_q;
  logic [15:0] time_dec;
  logic [3:0]  beep_cnt_q;
  logic        key_ok;
  logic        start_ok;
  logic        time_zero;

  assign state = state_q;
  assign {min_tens, min_ones, sec_tens, sec_ones} = time_q;

  assign key_ok    = key_valid && (key_digit <= 4'd9);
  assign start_ok  = start && door_closed;
  assign time_zero = (time_q == 16'h0000);

  // Per-digit borrow chain; seconds tens wrap to 5, other digits to 9.
  always_comb begin
    time_dec = time_q;
    if (time_q[3:0] != 4'd0) begin
      time_dec[3:0] = time_q[3:0] - 4'd1;
    end else begin
      time_dec[3:0] = 4'd9;
      if (time_q[7:4] != 4'd0) begin
        time_dec[7:4] = time_q[7:4] - 4'd1;
      end else begin
        time_dec[7:4] = 4'd5;
        if (time_q[11:8] != 4'd0) begin
          time_dec[11:8] = time_q[11:8] - 4'd1;
        end else begin
          time_dec[11:8]  = 4'd9;
          time_dec[15:12] = time_q[15:12] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      time_q       <= 16'h0000;
      beep_cnt_q   <= 4'd0;
      magnetron_on <= 1'b0;
      beep         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (stop_clear) begin
            time_q <= 16'h0000;
          end else if (start_ok) begin
            time_q       <= QUICK_START;
            state_q      <= StCook;
            magnetron_on <= 1'b1;
          end else if (key_ok) begin
            time_q  <= {time_q[11:0], key_digit};
            state_q <= StSet;
          end
        end
        StSet: begin
          if (stop_clear) begin
            time_q  <= 16'h0000;
            state_q <= StIdle;
          end else if (start_ok) begin
            if (time_zero) time_q <= QUICK_START;
            state_q      <= StCook;
            magnetron_on <= 1'b1;
          end else if (key_ok) begin
            time_q <= {time_q[11:0], key_digit};
          end
        end
        StCook: begin
          if (stop_clear || !door_closed) begin
            state_q      <= StPause;
            magnetron_on <= 1'b0;
          end else if (tick_1hz) begin
            time_q <= time_dec;
            if (time_dec == 16'h0000) begin
              state_q      <= StDone;
              magnetron_on <= 1'b0;
              beep         <= 1'b1;
              done         <= 1'b1;
              beep_cnt_q   <= 4'd0;
            end
          end
        end
        StPause: begin
          if (stop_clear) begin
            time_q  <= 16'h0000;
            state_q <= StIdle;
          end else if (start_ok) begin
            state_q      <= StCook;
            magnetron_on <= 1'b1;
          end
        end
        StDone: begin
          if (stop_clear || !door_closed || start || key_valid) begin
            state_q    <= StIdle;
            beep       <= 1'b0;
            beep_cnt_q <= 4'd0;
          end else if (tick_1hz) begin
            if (beep_cnt_q == BEEP_SECS - 4'd1) begin
              state_q    <= StIdle;
              beep       <= 1'b0;
              beep_cnt_q <= 4'd0;
            end else begin
              beep_cnt_q <= beep_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_q      <= StIdle;
          time_q       <= 16'h0000;
          beep_cnt_q   <= 4'd0;
          magnetron_on <= 1'b0;
          beep         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microwave_timer.sv
// Bench for microwave_timer: directed scenarios plus random traffic, all checked
// against a minutes/seconds arithmetic model of the timer.
module tb_microwave_timer;

  localparam logic [15:0] QS = 16'h0030;
  localparam int          BS = 3;

  localparam logic [2:0] M_IDLE = 3'd0, M_SET = 3'd1, M_COOK = 3'd2, M_PAUSE = 3'd3,
                         M_DONE = 3'd4;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, key_valid, start, stop_clear, door_closed;
  logic [3:0] key_digit;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       magnetron_on, beep, done;
  logic [2:0] state;

  microwave_timer #(
    .QUICK_START(QS),
    .BEEP_SECS  (4'(BS))
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .stop_clear  (stop_clear),
    .door_closed (door_closed),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .magnetron_on(magnetron_on),
    .beep        (beep),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: time held as minutes and seconds integers (seconds may exceed 59).
  logic [2:0]  m_state;
  int          m_mm, m_ss, m_bcnt;
  bit          m_mag, m_beep, m_done;
  logic [15:0] qs_v = QS;

  function automatic logic [7:0] bcd2(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic logic [21:0] exp_vec();
    return {m_state, bcd2(m_mm), bcd2(m_ss), m_mag, m_beep, m_done};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {state, min_tens, min_ones, sec_tens, sec_ones, magnetron_on, beep, done};
  endfunction

  function automatic logic [15:0] dut_time();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic model_load_qs();
    m_mm = int'(qs_v[15:12]) * 10 + int'(qs_v[11:8]);
    m_ss = int'(qs_v[7:4]) * 10 + int'(qs_v[3:0]);
  endtask

  task automatic model_step(input bit r, t, kv, input int kd, input bit st, sc, dc);
    m_done = 1'b0;
    if (r) begin
      m_state = M_IDLE; m_mm = 0; m_ss = 0; m_bcnt = 0;
    end else begin
      case (m_state)
        M_IDLE, M_SET: begin
          if (sc) begin
            m_mm = 0; m_ss = 0; m_state = M_IDLE;
          end else if (st && dc) begin
            if (m_state == M_IDLE || (m_mm == 0 && m_ss == 0)) model_load_qs();
            m_state = M_COOK;
          end else if (kv && kd <= 9) begin
            m_mm = (m_mm % 10) * 10 + m_ss / 10;
            m_ss = (m_ss % 10) * 10 + kd;
            m_state = M_SET;
          end
        end
        M_COOK: begin
          if (sc || !dc) begin
            m_state = M_PAUSE;
          end else if (t) begin
            if (m_ss > 0) m_ss = m_ss - 1;
            else begin m_ss = 59; m_mm = m_mm - 1; end
            if (m_mm == 0 && m_ss == 0) begin
              m_state = M_DONE; m_done = 1'b1; m_bcnt = 0;
            end
          end
        end
        M_PAUSE: begin
          if (sc) begin
            m_mm = 0; m_ss = 0; m_state = M_IDLE;
          end else if (st && dc) begin
            m_state = M_COOK;
          end
        end
        default: begin
          if (sc || !dc || st || kv) begin
            m_state = M_IDLE; m_bcnt = 0;
          end else if (t) begin
            m_bcnt = m_bcnt + 1;
            if (m_bcnt == BS) begin m_state = M_IDLE; m_bcnt = 0; end
          end
        end
      endcase
    end
    m_mag  = (m_state == M_COOK);
    m_beep = (m_state == M_DONE);
  endtask

  task automatic apply(input bit r, t, kv, input logic [3:0] kd, input bit st, sc, dc);
    rst = r; tick_1hz = t; key_valid = kv; key_digit = kd;
    start = st; stop_clear = sc; door_closed = dc;
    model_step(r, t, kv, int'(kd), st, sc, dc);
    @(posedge clk);
    #1;
    rst = 1'b0; tick_1hz = 1'b0; key_valid = 1'b0; start = 1'b0; stop_clear = 1'b0;
  endtask

  task automatic do_rst();          apply(1, 0, 0, 4'd0, 0, 0, 1); endtask
  task automatic press(input logic [3:0] d); apply(0, 0, 1, d, 0, 0, 1); endtask
  task automatic push_start();      apply(0, 0, 0, 4'd0, 1, 0, 1); endtask
  task automatic tick();            apply(0, 1, 0, 4'd0, 0, 0, 1); endtask
  task automatic idle();            apply(0, 0, 0, 4'd0, 0, 0, 1); endtask
  task automatic push_stop();       apply(0, 0, 0, 4'd0, 0, 1, 1); endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1, 1, 1, 4'd7, 1, 1, 1);
      n_checks++;
      if (dut_vec() !== 22'h0) $display("FAIL reset[%0d]: got %h expected %h", i, dut_vec(), 22'h0);
      else n_pass++;
    end
  endtask

  task automatic test_entry();
    logic [3:0] keys [4] = '{4'd1, 4'd12, 4'd2, 4'd3};
    do_rst();
    for (int i = 0; i < 4; i++) begin
      press(keys[i]);
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL entry[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (dut_time() !== 16'h0123 || state !== 3'd1)
      $display("FAIL entry_0123: got %h/%0d expected 0123/1", dut_time(), state);
    else n_pass++;
    push_start();
    n_checks++;
    if (magnetron_on !== 1'b1 || state !== 3'd2 || dut_time() !== 16'h0123)
      $display("FAIL entry_cook: got mag=%b st=%0d t=%h expected 1/2/0123", magnetron_on, state,
               dut_time());
    else n_pass++;
  endtask

  task automatic test_countdown();
    do_rst(); press(4'd1); press(4'd0); press(4'd0); push_start();
    for (int i = 1; i <= 60; i++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL countdown[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      else n_pass++;
      if (i == 1) begin
        n_checks++;
        if (dut_time() !== 16'h0059) $display("FAIL countdown_0059: got %h expected 0059", dut_time());
        else n_pass++;
      end
      if (i == 60) begin
        n_checks++;
        if ({state, done, beep, magnetron_on} !== {3'd4, 3'b110} || dut_time() !== 16'h0)
          $display("FAIL countdown_done: got st=%0d done=%b beep=%b mag=%b expected 4/1/1/0", state,
                   done, beep, magnetron_on);
        else n_pass++;
      end else begin
        idle();
      end
    end
    idle();
    n_checks++;
    if (done !== 1'b0 || beep !== 1'b1) $display("FAIL done_pulse: got done=%b beep=%b expected 0/1", done, beep);
    else n_pass++;
    for (int k = 1; k <= BS; k++) begin
      tick();
      n_checks++;
      if (beep !== (k < BS) || state !== ((k < BS) ? 3'd4 : 3'd0))
        $display("FAIL beep[%0d]: got beep=%b st=%0d expected %b", k, beep, state, k < BS);
      else n_pass++;
      idle();
    end
  endtask

  task automatic test_door_pause();
    do_rst(); press(4'd1); press(4'd0); push_start();
    apply(0, 1, 0, 4'd0, 0, 0, 0);
    n_checks++;
    if (state !== 3'd3 || dut_time() !== 16'h0010 || magnetron_on !== 1'b0)
      $display("FAIL door_pause: got st=%0d t=%h mag=%b expected 3/0010/0", state, dut_time(), magnetron_on);
    else n_pass++;
    apply(0, 1, 1, 4'd5, 0, 0, 0);
    idle(); push_start(); tick();
    n_checks++;
    if (dut_vec() !== exp_vec() || dut_time() !== 16'h0009)
      $display("FAIL door_resume: got %h expected %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_quick_start();
    do_rst();
    apply(0, 0, 0, 4'd0, 1, 0, 0);
    n_checks++;
    if (state !== 3'd0 || dut_time() !== 16'h0) $display("FAIL qs_door_open: got st=%0d t=%h expected 0/0000", state, dut_time());
    else n_pass++;
    push_start();
    n_checks++;
    if (state !== 3'd2 || dut_time() !== 16'h0030 || magnetron_on !== 1'b1)
      $display("FAIL qs_idle: got st=%0d t=%h expected 2/0030", state, dut_time());
    else n_pass++;
    do_rst(); press(4'd0); push_start();
    n_checks++;
    if (state !== 3'd2 || dut_time() !== 16'h0030) $display("FAIL qs_set_zero: got st=%0d t=%h expected 2/0030", state, dut_time());
    else n_pass++;
  endtask

  task automatic test_unnormalised();
    do_rst(); press(4'd9); press(4'd9); push_start();
    tick(); tick(); tick();
    n_checks++;
    if (dut_time() !== 16'h0096 || state !== 3'd2) $display("FAIL unnorm_96: got %h expected 0096", dut_time());
    else n_pass++;
    push_stop();
    n_checks++;
    if (state !== 3'd3 || dut_time() !== 16'h0096) $display("FAIL unnorm_pause: got st=%0d t=%h expected 3/0096", state, dut_time());
    else n_pass++;
    push_stop();
    n_checks++;
    if (state !== 3'd0 || dut_time() !== 16'h0) $display("FAIL unnorm_clear: got st=%0d t=%h expected 0/0000", state, dut_time());
    else n_pass++;
  endtask

  task automatic test_reset_mid_cook();
    do_rst(); press(4'd5); push_start(); tick();
    apply(1, 1, 0, 4'd0, 0, 0, 1);
    n_checks++;
    if (dut_vec() !== 22'h0) $display("FAIL reset_mid_cook: got %h expected %h", dut_vec(), 22'h0);
    else n_pass++;
  endtask

  task automatic test_random();
    do_rst();
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2,
            4'($urandom_range(0, 11)), $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 9) != 0);
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b0; tick_1hz = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    start = 1'b0; stop_clear = 1'b0; door_closed = 1'b1;
    m_state = M_IDLE; m_mm = 0; m_ss = 0; m_bcnt = 0;
    m_mag = 1'b0; m_beep = 1'b0; m_done = 1'b0;
    test_reset();
    test_entry();
    test_countdown();
    test_door_pause();
    test_quick_start();
    test_unnormalised();
    test_reset_mid_cook();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
